// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: glyph patterns
// ({g,f,e,d,c,b,a}, active-low), widths and slot-length helper.
package seg7_pkg;

    localparam int NIB_W = 4;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_HA    = 7'b0001000;
    localparam logic [6:0] GLYPH_HB    = 7'b0000011;
    localparam logic [6:0] GLYPH_HC    = 7'b1000110;
    localparam logic [6:0] GLYPH_HD    = 7'b0100001;
    localparam logic [6:0] GLYPH_HE    = 7'b0000110;
    localparam logic [6:0] GLYPH_HF    = 7'b0001110;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic int slot_cyc(
        input int clk_hz,
        input int refresh_hz,
        input int num_digits
    );
        return clk_hz / (refresh_hz * num_digits);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Nibble to active-low 7-segment pattern. hex_mode=0 keeps the
// legacy table where A shows a dash and F is dark.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        unique case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = hex_mode ? GLYPH_HA : GLYPH_DASH;
            4'hB: glyph = GLYPH_HB;
            4'hC: glyph = GLYPH_HC;
            4'hD: glyph = GLYPH_HD;
            4'hE: glyph = GLYPH_HE;
            4'hF: glyph = hex_mode ? GLYPH_HF : GLYPH_BLANK;
            default: glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered N-digit 7-segment scanner with ghost gaps.
// Define SEG7_DIM_EN to add the bright[3:0] PWM dimming input.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_HZ         = 100_000_000,
    parameter int REFRESH_HZ     = 1000,
    parameter int GHOST_CYC      = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    hex_mode,
`ifdef SEG7_DIM_EN
    input  logic [3:0]              bright,
`endif
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_pulse
);

    localparam int SLOT_CYC = slot_cyc(CLK_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam int CW = $clog2(SLOT_CYC);
    localparam int IW = idx_w(NUM_DIGITS);
    localparam int DW = NIB_W * NUM_DIGITS;

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] GHOST     = CW'(GHOST_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic       DP_INV  = !SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_INV =
        AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    localparam logic [6:0] SEG_OFF = GLYPH_BLANK ^ SEG_INV;
    localparam logic       DP_OFF  = 1'b1 ^ DP_INV;

    logic [CW-1:0]         slot_cnt;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         sh_digits, act_digits;
    logic [NUM_DIGITS-1:0] sh_blank, act_blank;
    logic [NUM_DIGITS-1:0] sh_dp, act_dp;

    logic                  slot_wrap;
    logic                  frame_wrap;
    logic                  lit;
    logic                  gate;
    logic [3:0]            cur_nib;
    logic [6:0]            glyph;
    logic [6:0]            seg_low;
    logic                  dp_low;
    logic [NUM_DIGITS-1:0] an_on;

    assign slot_wrap   = (slot_cnt == SLOT_LAST);
    assign frame_wrap  = slot_wrap && (idx == IDX_LAST);
    assign frame_pulse = frame_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Shadow takes every load; active only changes at frame wrap,
    // with a same-cycle load bypassing straight into active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits  <= '1;
            sh_blank   <= '1;
            sh_dp      <= '0;
            act_digits <= '1;
            act_blank  <= '1;
            act_dp     <= '0;
        end else begin
            if (load) begin
                sh_digits <= digits;
                sh_blank  <= blank;
                sh_dp     <= dp;
            end
            if (frame_wrap) begin
                act_digits <= load ? digits : sh_digits;
                act_blank  <= load ? blank  : sh_blank;
                act_dp     <= load ? dp     : sh_dp;
            end
        end
    end

`ifdef SEG7_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign gate = (pwm_cnt <= bright);
`else
    assign gate = 1'b1;
`endif

    assign cur_nib = act_digits[{idx, 2'b00} +: 4];

    seg7_glyph_rom u_rom (
        .nibble   (cur_nib),
        .hex_mode (hex_mode),
        .glyph    (glyph)
    );

    assign seg_low = act_blank[idx] ? GLYPH_BLANK : glyph;
    assign dp_low  = ~(act_dp[idx] & ~act_blank[idx]);
    assign an_on   = NUM_DIGITS'(1) << idx;
    assign lit     = (slot_cnt != '0) && (slot_cnt >= GHOST) && gate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= SEG_OFF;
            dp_out <= DP_OFF;
            an     <= AN_INV;
        end else begin
            if (slot_cnt == '0) begin
                seg    <= seg_low ^ SEG_INV;
                dp_out <= dp_low ^ DP_INV;
            end
            an <= lit ? (an_on ^ AN_INV) : AN_INV;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed table-driven bench for seg7_scan_driver
// (4 digits, 20-cycle slots, 2-cycle ghost gap, 80-cycle frame).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  dp = '0;
    logic        hex_mode = 1'b0;
`ifdef SEG7_DIM_EN
    logic [3:0]  bright = 4'hF;
`endif
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_pulse;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .CLK_HZ         (80_000),
        .REFRESH_HZ     (1000),
        .GHOST_CYC      (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .digits      (digits),
        .blank       (blank),
        .dp          (dp),
        .hex_mode    (hex_mode),
`ifdef SEG7_DIM_EN
        .bright      (bright),
`endif
        .seg         (seg),
        .dp_out      (dp_out),
        .an          (an),
        .frame_pulse (frame_pulse)
    );

    typedef enum int { K_CHK, K_LD, K_HX, K_RST } kind_t;

    typedef struct {
        kind_t       k;
        int          e;
        logic [15:0] dg;
        logic [3:0]  bl;
        logic [3:0]  dpi;
        logic        hx;
        logic [6:0]  sg;
        logic        dpo;
        logic [3:0]  an;
        logic        fp;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nbad = 0;
    int   e = 0;

    function automatic void chk(int t, logic [6:0] s, logic d,
                                logic [3:0] a, logic f);
        tbl.push_back('{K_CHK, t, 16'h0, 4'h0, 4'h0, 1'b0,
                        s, d, a, f});
    endfunction

    function automatic void ld(int t, logic [15:0] g, logic [3:0] b,
                               logic [3:0] p, logic h);
        tbl.push_back('{K_LD, t, g, b, p, h, 7'h0, 1'b0, 4'h0, 1'b0});
    endfunction

    function automatic void act(kind_t k, int t, logic h);
        tbl.push_back('{k, t, 16'h0, 4'h0, 4'h0, h,
                        7'h0, 1'b0, 4'h0, 1'b0});
    endfunction

    task automatic cmp(string nm, logic [15:0] got, logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s e=%0d got=%h want=%h", nm, e, got, exp);
        end
    endtask

    task automatic goto(int t);
        while (e < t) begin
            @(posedge clk);
            #1 load = 1'b0;
            e++;
            @(negedge clk);
        end
    endtask

    task automatic rst_check();
        cmp("rst_an", 16'(an), 16'hF);
        cmp("rst_seg", 16'(seg), 16'h7F);
        cmp("rst_dp", 16'(dp_out), 16'h1);
        cmp("rst_fp", 16'(frame_pulse), 16'h0);
    endtask

    initial begin
        int lit_n;

        chk(1,   7'h7F, 1'b1, 4'hF, 1'b0);
        chk(5,   7'h7F, 1'b1, 4'hE, 1'b0);
        ld (10,  16'h1234, 4'b0000, 4'b0100, 1'b0);
        chk(65,  7'h7F, 1'b1, 4'h7, 1'b0);
        chk(78,  7'h7F, 1'b1, 4'h7, 1'b0);
        chk(79,  7'h7F, 1'b1, 4'h7, 1'b1);
        chk(81,  7'h19, 1'b1, 4'hF, 1'b0);
        chk(82,  7'h19, 1'b1, 4'hF, 1'b0);
        chk(83,  7'h19, 1'b1, 4'hE, 1'b0);
        chk(100, 7'h19, 1'b1, 4'hE, 1'b0);
        chk(101, 7'h30, 1'b1, 4'hF, 1'b0);
        chk(121, 7'h24, 1'b0, 4'hF, 1'b0);
        chk(125, 7'h24, 1'b0, 4'hB, 1'b0);
        chk(150, 7'h79, 1'b1, 4'h7, 1'b0);
        chk(159, 7'h79, 1'b1, 4'h7, 1'b1);
        ld (170, 16'hFA00, 4'b0000, 4'b0000, 1'b0);
        chk(241, 7'h40, 1'b1, 4'hF, 1'b0);
        chk(281, 7'h3F, 1'b1, 4'hF, 1'b0);
        chk(301, 7'h7F, 1'b1, 4'hF, 1'b0);
        act(K_HX, 305, 1'b1);
        chk(310, 7'h7F, 1'b1, 4'h7, 1'b0);
        chk(321, 7'h40, 1'b1, 4'hF, 1'b0);
        ld (330, 16'h5555, 4'b0000, 4'b0000, 1'b1);
        chk(361, 7'h08, 1'b1, 4'hF, 1'b0);
        chk(381, 7'h0E, 1'b1, 4'hF, 1'b0);
        chk(401, 7'h12, 1'b1, 4'hF, 1'b0);
        chk(441, 7'h12, 1'b1, 4'hF, 1'b0);
        chk(479, 7'h12, 1'b1, 4'h7, 1'b1);
        ld (479, 16'h0789, 4'b0010, 4'b0010, 1'b1);
        chk(481, 7'h10, 1'b1, 4'hF, 1'b0);
        chk(501, 7'h7F, 1'b1, 4'hF, 1'b0);
        chk(521, 7'h78, 1'b1, 4'hF, 1'b0);
        chk(541, 7'h40, 1'b1, 4'hF, 1'b0);
        chk(610, 7'h78, 1'b1, 4'hB, 1'b0);
        act(K_RST, 610, 1'b1);
        chk(5,   7'h7F, 1'b1, 4'hE, 1'b0);
        chk(79,  7'h7F, 1'b1, 4'h7, 1'b1);
        chk(81,  7'h7F, 1'b1, 4'hF, 1'b0);
        ld (90,  16'hEDCB, 4'b0000, 4'b0001, 1'b0);
        chk(161, 7'h03, 1'b0, 4'hF, 1'b0);
        chk(181, 7'h46, 1'b1, 4'hF, 1'b0);
        chk(201, 7'h21, 1'b1, 4'hF, 1'b0);
        chk(221, 7'h06, 1'b1, 4'hF, 1'b0);
        ld (230, 16'h0086, 4'b0000, 4'b0000, 1'b1);
        chk(241, 7'h02, 1'b1, 4'hF, 1'b0);
        chk(261, 7'h00, 1'b1, 4'hF, 1'b0);
        chk(281, 7'h40, 1'b1, 4'hF, 1'b0);

        repeat (3) @(negedge clk);
        rst_check();
        rst_n = 1'b1;
        e = 0;

        foreach (tbl[i]) begin
            goto(tbl[i].e);
            case (tbl[i].k)
                K_CHK: cmp($sformatf("vec%0d", i),
                           16'({frame_pulse, an, dp_out, seg}),
                           16'({tbl[i].fp, tbl[i].an,
                                tbl[i].dpo, tbl[i].sg}));
                K_LD: begin
                    digits   = tbl[i].dg;
                    blank    = tbl[i].bl;
                    dp       = tbl[i].dpi;
                    hex_mode = tbl[i].hx;
                    load     = 1'b1;
                end
                K_HX: hex_mode = tbl[i].hx;
                K_RST: begin
                    rst_n = 1'b0;
                    #1;
                    rst_check();
                    repeat (2) @(posedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                    load = 1'b0;
                    e = 0;
                end
                default: ;
            endcase
        end

`ifdef SEG7_DIM_EN
        bright = 4'd3;
        goto(282);
        lit_n = 0;
        for (int j = 0; j < 16; j++) begin
            goto(e + 1);
            if (an != 4'hF) lit_n++;
        end
        cmp("dim_duty", 16'(lit_n), 16'd4);
`else
        lit_n = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
